// File: rtl/rll_key_loader_if.sv
// Serial key beat channel into the RLL key loader.
// One data/parity bit per accepted beat, s_last on the final beat.
interface rll_key_loader_if;
  logic s_valid;
  logic s_ready;
  logic s_data;
  logic s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/rll_key_loader.sv
// Serial key loader for a logic-locked netlist: parity check,
// fail counting with lockout, and zeroisation on clear.
module rll_key_loader #(
  parameter int KEY_W    = 16,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  rll_key_loader_if.slave  s,
  input  logic             clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             err,
  output logic             lockout
);

  localparam int CW = $clog2(KEY_W + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [CW-1:0] KW = CW'(KEY_W);
  localparam logic [FW-1:0] MF = FW'(MAX_FAIL);

  typedef enum logic [2:0] {
    IDLE, SHIFT, DRAIN, CHECK, HOLD, LOCKOUT
  } state_t;

  state_t state, state_nx;

  logic [KEY_W-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par;
  logic             bad;
  logic [FW-1:0]    fails;
  logic [FW-1:0]    fails_inc;
  logic             accept;
  logic             pass;

  assign accept    = s.s_valid & s.s_ready;
  assign pass      = ~bad & ~par;
  assign fails_inc = (fails == MF) ? fails : fails + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, HOLD: begin
        if (clear)
          state_nx = IDLE;
        else if (s.s_valid)
          state_nx = s.s_last ? CHECK : SHIFT;
      end
      SHIFT: begin
        if (clear)
          state_nx = IDLE;
        else if (s.s_valid) begin
          if (s.s_last)
            state_nx = CHECK;
          else if (cnt == KW)
            state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (clear)
          state_nx = IDLE;
        else if (s.s_valid && s.s_last)
          state_nx = CHECK;
      end
      CHECK: begin
        if (pass)
          state_nx = HOLD;
        else if (fails_inc == MF)
          state_nx = LOCKOUT;
        else
          state_nx = IDLE;
      end
      LOCKOUT: state_nx = LOCKOUT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s.s_ready = 1'b0;
    lockout   = 1'b0;
    unique case (state)
      IDLE, SHIFT, DRAIN, HOLD: s.s_ready = ~clear;
      LOCKOUT:                  lockout   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      cnt       <= '0;
      par       <= 1'b0;
      bad       <= 1'b0;
      fails     <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (clear) begin
            key_out   <= '0;
            key_valid <= 1'b0;
          end else if (accept) begin
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            shreg     <= KEY_W'(s.s_data);
            cnt       <= CW'(1);
            par       <= s.s_data;
            bad       <= s.s_last;
          end
        end
        SHIFT: begin
          if (clear) begin
            cnt <= '0;
            par <= 1'b0;
          end else if (accept) begin
            par <= par ^ s.s_data;
            // the beat at index KEY_W is parity: it must carry s_last
            if (cnt == KW) begin
              bad <= ~s.s_last;
            end else begin
              for (int i = 0; i < KEY_W; i++)
                if (cnt == CW'(i)) shreg[i] <= s.s_data;
              cnt <= cnt + 1'b1;
              bad <= s.s_last;
            end
          end
        end
        DRAIN: begin
          if (clear) begin
            cnt <= '0;
            par <= 1'b0;
          end
        end
        CHECK: begin
          cnt <= '0;
          par <= 1'b0;
          if (pass) begin
            key_out   <= shreg;
            key_valid <= 1'b1;
            fails     <= '0;
          end else begin
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b1;
            fails     <= fails_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
